rf_xfer_ctrl: RTL and testbench
===============================

# rf_xfer_ctrl

Register-transfer sequencer that drives the single-port CPU register file as its initiator. Executes the 6502 implied-mode transfers (TAX, TAY, TXA, TYA, TSX, TXS) by reading the source register, writing the destination, and read-modify-writing the N/Z bits of P. It sits between the instruction decoder (request side) and the register file port (address / write-enable / write-data out, read-data in).

## Interface
- `DATA_W`, default 16: register-file port width. Only the low `REG_W` bits carry data; upper bits are written 0 and ignored on read.
- `REG_W`, default 8: architectural register width.

Ports:
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  transfer request.
- `req_op_i`  in  `xfer_op_t` (3)  opcode: TAX=0, TAY=1, TXA=2, TYA=3, TSX=4, TXS=5; 6 and 7 are illegal.
- `req_ready_o`  out  1  request accepted when `req_valid_i && req_ready_o` at a rising edge.
- `busy_o`  out  1  FSM not in IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  one-cycle pulse, coincident with `done_o`, for an illegal op.
- `rf_addr_o`  out  `reg_id_t`  register file address: A=0, X=1, Y=2, SP=3, P=4.
- `rf_we_o`  out  1  register file write enable.
- `rf_wdata_o`  out  `DATA_W`  register file write data.
- `rf_rdata_i`  in  `DATA_W`  register file combinational read data for `rf_addr_o`.

## Operation
- FSM states: IDLE, RD_SRC, WR_DST, RD_P, WR_P, DONE.
- IDLE:
  - `req_ready_o` = 1.
  - On handshake, latch the op and decode `src`/`dst`. Go to RD_SRC, or to DONE with the error flag set for ops 6/7.
- RD_SRC:
  - `rf_addr_o` = `src`.
  - At the edge, latch `rf_rdata_i[REG_W-1:0]` into `val`.
  - Go to WR_DST.
- WR_DST:
  - `rf_addr_o` = `dst`, `rf_we_o` = 1, `rf_wdata_o` = zero-extended `val`.
  - Go to DONE for TXS; go to RD_P for every other op.
- RD_P:
  - `rf_addr_o` = P.
  - Latch `rf_rdata_i[7:0]` into `pval`.
  - Go to WR_P.
- WR_P:
  - `rf_addr_o` = P, `rf_we_o` = 1.
  - `rf_wdata_o` = `pval` with bit7 (N) = `val[7]` and bit1 (Z) = (`val` == 0). All other P bits are preserved.
  - Go to DONE.
- DONE:
  - `done_o` = 1; `err_o` = the latched error flag.
  - No handshake is accepted. Go to IDLE.
- Outside the write states: `rf_we_o` = 0 and `rf_wdata_o` = 0. In IDLE and DONE, `rf_addr_o` = A (0).
- TXS deliberately leaves P untouched: P is never addressed for write.
- Illegal ops issue no register file access at all.
- `req_op_i` is sampled only at the handshake. Later changes have no effect.

## Timing
- Reset (async assert, sync-released by the system):
  - State goes to IDLE.
  - `req_ready_o` = 1 during reset; `busy_o`, `done_o`, `err_o`, `rf_we_o` = 0; `rf_addr_o` = 0; `rf_wdata_o` = 0.
  - `val`, `pval` and the error flag clear to 0.
- Latency, counted from the handshake edge as cycle 0:
  - Flag-updating ops: RD_SRC in cycle 1, WR_DST in 2, RD_P in 3, WR_P in 4, `done_o` in cycle 5, ready again in cycle 6.
  - TXS: `done_o` in cycle 3.
  - Illegal op: `done_o` and `err_o` in cycle 1.
- Throughput: with `req_valid_i` held high, the next request is accepted at the first IDLE edge after DONE. Back-to-back TAX requests are therefore 6 cycles apart.
- Reset mid-operation: `rf_we_o` drops combinationally with `rstn_i` low. The partial transfer is abandoned: the destination may or may not already be written, and P is not written. No `done_o` is issued for the abandoned transfer.
- All outputs are registered-state decodes; there is no combinational path from `req_*` to `rf_*`.
- `rf_rdata_i` is consumed in the same cycle its address is presented.

## Structure
- The shared CPU package holds:
  - `BYTE` = 8.
  - `reg_id_t` (enum A, X, Y, SP, P).
  - `xfer_op_t`.
  - Flag bit constants `FLAG_N` = 7 and `FLAG_Z` = 1.
  - A pure function `xfer_decode(op) -> {src, dst, upd_flags, illegal}`.
- State enum: local to the module.
- No sub-module; a single FSM with datapath registers `val` and `pval`.

## Test plan
- Reset: assert `rstn_i` mid-idle → `req_ready_o` = 1, all other outputs 0. Release, then read A..P through the bench model → no spurious writes.
- TAX with A=0x80, P=0x00:
  - Writes X=0x0080 in cycle 2 and P=0x0080 in cycle 4.
  - `done_o` in cycle 5; `err_o` = 0.
- TYA with Y=0x00, P=0x7C → A=0x0000, P=0x007E (Z set, N clear), `done_o` in cycle 5.
- TXS with X=0xFF, P=0x00:
  - SP=0x00FF written in cycle 2; P never addressed with `rf_we_o` = 1.
  - `done_o` in cycle 3.
- Illegal op 6 → `done_o` and `err_o` in cycle 1, `rf_we_o` never asserted, next request accepted in cycle 2.
- Reset pulse during WR_P of a TSX → `rf_we_o` falls immediately, state IDLE, no `done_o`. After release, a TAX with A=0x01 completes normally with P N=0, Z=0.

Source files
------------

// File: rtl/rf_xfer_ctrl_pkg.sv
// Shared CPU definitions for the register-transfer sequencer: register ids, transfer
// opcodes, flag bit positions and the opcode decoder.
package rf_xfer_ctrl_pkg;

  localparam int BYTE   = 8;
  localparam int FLAG_N = 7;
  localparam int FLAG_Z = 1;

  typedef enum logic [2:0] {
    REG_A  = 3'd0,
    REG_X  = 3'd1,
    REG_Y  = 3'd2,
    REG_SP = 3'd3,
    REG_P  = 3'd4
  } reg_id_t;

  typedef enum logic [2:0] {
    OP_TAX  = 3'd0,
    OP_TAY  = 3'd1,
    OP_TXA  = 3'd2,
    OP_TYA  = 3'd3,
    OP_TSX  = 3'd4,
    OP_TXS  = 3'd5,
    OP_ILL6 = 3'd6,
    OP_ILL7 = 3'd7
  } xfer_op_t;

  typedef struct packed {
    reg_id_t src;
    reg_id_t dst;
    logic    upd_flags;
    logic    illegal;
  } xfer_dec_t;

  function automatic xfer_dec_t xfer_decode(input xfer_op_t op);
    xfer_dec_t d;
    d.src       = REG_A;
    d.dst       = REG_A;
    d.upd_flags = 1'b1;
    d.illegal   = 1'b0;
    case (op)
      OP_TAX: begin d.src = REG_A;  d.dst = REG_X;  end
      OP_TAY: begin d.src = REG_A;  d.dst = REG_Y;  end
      OP_TXA: begin d.src = REG_X;  d.dst = REG_A;  end
      OP_TYA: begin d.src = REG_Y;  d.dst = REG_A;  end
      OP_TSX: begin d.src = REG_SP; d.dst = REG_X;  end
      // Loading the stack pointer is not an arithmetic result, so P stays as is.
      OP_TXS: begin d.src = REG_X;  d.dst = REG_SP; d.upd_flags = 1'b0; end
      default: begin
        d.upd_flags = 1'b0;
        d.illegal   = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rf_xfer_ctrl_if.sv
// Request and register-file port bundle of the transfer sequencer.
// slave is the sequencer's view; master is the decoder plus register file side.
interface rf_xfer_ctrl_if #(
  parameter int DATA_W = 16
) ();
  import rf_xfer_ctrl_pkg::*;

  logic              req_valid_i;
  xfer_op_t          req_op_i;
  logic              req_ready_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  reg_id_t           rf_addr_o;
  logic              rf_we_o;
  logic [DATA_W-1:0] rf_wdata_o;
  logic [DATA_W-1:0] rf_rdata_i;

  modport slave (
    input  req_valid_i, req_op_i, rf_rdata_i,
    output req_ready_o, busy_o, done_o, err_o, rf_addr_o, rf_we_o, rf_wdata_o
  );

  modport master (
    output req_valid_i, req_op_i, rf_rdata_i,
    input  req_ready_o, busy_o, done_o, err_o, rf_addr_o, rf_we_o, rf_wdata_o
  );

endinterface

// File: rtl/rf_xfer_ctrl.sv
// Sequencer for the 6502 implied-mode register transfers: read source, write
// destination, then read-modify-write N/Z in P, all through the single RF port.
module rf_xfer_ctrl
  import rf_xfer_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  rf_xfer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_SRC = 3'd1,
    S_WR_DST = 3'd2,
    S_RD_P   = 3'd3,
    S_WR_P   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  xfer_dec_t         dec_q, dec_new;
  logic [REG_W-1:0]  val_q;
  logic [BYTE-1:0]   pval_q;

  logic              ready, busy, done, err, we;
  reg_id_t           addr;
  logic [DATA_W-1:0] wdata;

  // Only the low byte(s) of the read port carry data; the rest is ignored.
  logic unused_rdata;
  assign unused_rdata = ^bus.rf_rdata_i;

  function automatic logic [DATA_W-1:0] zext_reg(input logic [REG_W-1:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic [BYTE-1:0] p_merge(input logic [BYTE-1:0] p,
                                              input logic [REG_W-1:0] v);
    logic [BYTE-1:0] r;
    r         = p;
    r[FLAG_N] = v[BYTE-1];
    r[FLAG_Z] = (v == '0);
    return r;
  endfunction

  assign dec_new = xfer_decode(bus.req_op_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Every output is a decode of registered state only.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    we      = 1'b0;
    addr    = REG_A;
    wdata   = '0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (bus.req_valid_i) state_d = dec_new.illegal ? S_DONE : S_RD_SRC;
      end
      S_RD_SRC: begin
        addr    = dec_q.src;
        state_d = S_WR_DST;
      end
      S_WR_DST: begin
        addr    = dec_q.dst;
        we      = 1'b1;
        wdata   = zext_reg(val_q);
        state_d = dec_q.upd_flags ? S_RD_P : S_DONE;
      end
      S_RD_P: begin
        addr    = REG_P;
        state_d = S_WR_P;
      end
      S_WR_P: begin
        addr    = REG_P;
        we      = 1'b1;
        wdata   = DATA_W'(p_merge(pval_q, val_q));
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = dec_q.illegal;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath captures: op decode at handshake, source and P in their read states.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dec_q  <= '0;
      val_q  <= '0;
      pval_q <= '0;
    end else begin
      if (state_q == S_IDLE && bus.req_valid_i) dec_q <= dec_new;
      if (state_q == S_RD_SRC) val_q  <= bus.rf_rdata_i[REG_W-1:0];
      if (state_q == S_RD_P)   pval_q <= bus.rf_rdata_i[BYTE-1:0];
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.err_o       = err;
  assign bus.rf_addr_o   = addr;
  assign bus.rf_we_o     = we;
  assign bus.rf_wdata_o  = wdata;

  a_err_implies_done: assert property (@(posedge clk_i) disable iff (!rstn_i) err |-> done);
  a_done_one_cycle:   assert property (@(posedge clk_i) disable iff (!rstn_i) done |=> !done);
  a_illegal_no_write: assert property (@(posedge clk_i) disable iff (!rstn_i)
                                       (we |-> !dec_q.illegal));

endmodule

// File: tb/tb_rf_xfer_ctrl.sv
// Bench for rf_xfer_ctrl: register file model, write scoreboard, vector table and
// hand sequences for back-to-back, reset-in-idle and reset-mid-transfer cases.
module tb_rf_xfer_ctrl;
  import rf_xfer_ctrl_pkg::*;

  logic clk;
  logic rstn;
  logic pre_load;
  logic [15:0] pre_vals [5];
  logic [15:0] regs [8];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    reg_id_t     addr;
    logic [15:0] data;
  } wr_t;
  wr_t wq [$];

  typedef struct {
    xfer_op_t    op;
    logic [15:0] a, x, y, sp, p;
    logic        has_dst;
    reg_id_t     dst;
    logic [15:0] dst_val;
    logic        has_p;
    logic [15:0] p_val;
    int          lat;
    logic        err;
  } vec_t;
  vec_t vecs [11];

  rf_xfer_ctrl_if #(.DATA_W(16)) bus ();

  rf_xfer_ctrl #(.DATA_W(16), .REG_W(8)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rf_rdata_i = regs[bus.rf_addr_o];

  always_ff @(posedge clk) begin
    if (pre_load) begin
      for (int i = 0; i < 5; i++) regs[i] <= pre_vals[i];
    end else if (bus.rf_we_o) begin
      regs[bus.rf_addr_o] <= bus.rf_wdata_o;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_write(input string nm);
    wr_t e;
    if (bus.rf_we_o) begin
      if (wq.size() == 0) begin
        chk({nm, "_unexpected_write_addr"}, 32'(bus.rf_addr_o), 32'hFFFF_FFFF);
      end else begin
        e = wq.pop_front();
        chk({nm, "_wr_addr"}, 32'(bus.rf_addr_o), 32'(e.addr));
        chk({nm, "_wr_data"}, 32'(bus.rf_wdata_o), 32'(e.data));
      end
    end
  endtask

  task automatic load_regs(input logic [15:0] a, x, y, sp, p);
    @(negedge clk);
    pre_vals[0] = a;
    pre_vals[1] = x;
    pre_vals[2] = y;
    pre_vals[3] = sp;
    pre_vals[4] = p;
    pre_load    = 1'b1;
    @(negedge clk);
    pre_load = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    lat = 0;
    load_regs(v.a, v.x, v.y, v.sp, v.p);
    if (v.has_dst) wq.push_back('{v.dst, v.dst_val});
    if (v.has_p)   wq.push_back('{REG_P, v.p_val});
    bus.req_op_i    = v.op;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid_i = 1'b0;
      chk_write(nm);
      if (bus.done_o) begin
        lat = c;
        chk({nm, "_err"}, 32'(bus.err_o), 32'(v.err));
        break;
      end
    end
    chk({nm, "_done_cycle"}, 32'(lat), 32'(v.lat));
    @(negedge clk);
    chk({nm, "_ready_again"}, 32'(bus.req_ready_o), 32'd1);
    chk({nm, "_pending_writes"}, 32'(wq.size()), 32'd0);
    wq.delete();
    if (v.has_dst) chk({nm, "_dst_reg"}, 32'(regs[v.dst]), 32'(v.dst_val));
    chk({nm, "_p_reg"}, 32'(regs[REG_P]), 32'(v.has_p ? v.p_val : v.p));
  endtask

  initial begin
    vec_t tv;
    int   done1, done2, first_ready;
    logic err_seen;
    logic [15:0] exp_ld [5];

    rstn            = 1'b1;
    pre_load        = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = OP_TAX;
    for (int i = 0; i < 5; i++) pre_vals[i] = '0;

    //            op       a        x        y        sp       p        hd   dst     dval     hp   pval     lat err
    vecs[0]  = '{OP_TAX,  16'h0080,16'h0000,16'h0000,16'h0000,16'h0000,1'b1,REG_X, 16'h0080,1'b1,16'h0080,5, 1'b0};
    vecs[1]  = '{OP_TYA,  16'h0033,16'h0000,16'h0000,16'h0000,16'h007C,1'b1,REG_A, 16'h0000,1'b1,16'h007E,5, 1'b0};
    vecs[2]  = '{OP_TXS,  16'h0000,16'h00FF,16'h0000,16'h0000,16'h0000,1'b1,REG_SP,16'h00FF,1'b0,16'h0000,3, 1'b0};
    vecs[3]  = '{OP_TAY,  16'h0001,16'h0000,16'h0000,16'h0000,16'h00FF,1'b1,REG_Y, 16'h0001,1'b1,16'h007D,5, 1'b0};
    vecs[4]  = '{OP_TXA,  16'h0055,16'h0000,16'h0000,16'h0000,16'h0080,1'b1,REG_A, 16'h0000,1'b1,16'h0002,5, 1'b0};
    vecs[5]  = '{OP_TSX,  16'h0000,16'h0000,16'h0000,16'h00C3,16'h0002,1'b1,REG_X, 16'h00C3,1'b1,16'h0080,5, 1'b0};
    vecs[6]  = '{OP_TAX,  16'hAB7F,16'h0000,16'h0000,16'h0000,16'h5583,1'b1,REG_X, 16'h007F,1'b1,16'h0001,5, 1'b0};
    vecs[7]  = '{OP_ILL6, 16'h0011,16'h0022,16'h0033,16'h0044,16'h0055,1'b0,REG_A, 16'h0000,1'b0,16'h0000,1, 1'b1};
    vecs[8]  = '{OP_ILL7, 16'h0011,16'h0022,16'h0033,16'h0044,16'h0055,1'b0,REG_A, 16'h0000,1'b0,16'h0000,1, 1'b1};
    vecs[9]  = '{OP_TXS,  16'h0000,16'h1280,16'h0000,16'h0000,16'h0000,1'b1,REG_SP,16'h0080,1'b0,16'h0000,3, 1'b0};
    vecs[10] = '{OP_TYA,  16'h0000,16'h0000,16'h00FE,16'h0000,16'h0002,1'b1,REG_A, 16'h00FE,1'b1,16'h0080,5, 1'b0};

    // Power-on reset
    #1 rstn = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_busy",  32'(bus.busy_o),      32'd0);
    chk("rst_done",  32'(bus.done_o),      32'd0);
    chk("rst_err",   32'(bus.err_o),       32'd0);
    chk("rst_we",    32'(bus.rf_we_o),     32'd0);
    chk("rst_addr",  32'(bus.rf_addr_o),   32'd0);
    chk("rst_wdata", 32'(bus.rf_wdata_o),  32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Reset while idle must not disturb the register file
    exp_ld = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
    load_regs(exp_ld[0], exp_ld[1], exp_ld[2], exp_ld[3], exp_ld[4]);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("idle_rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("idle_rst_busy",  32'(bus.busy_o),      32'd0);
    chk("idle_rst_we",    32'(bus.rf_we_o),     32'd0);
    chk("idle_rst_addr",  32'(bus.rf_addr_o),   32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_rst_no_write", 32'(bus.rf_we_o), 32'd0);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("idle_rst_reg%0d", i), 32'(regs[i]), 32'(exp_ld[i]));

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back TAX with valid held high; op changes after acceptance are ignored
    load_regs(16'h0042, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    wq.push_back('{REG_X, 16'h0042});
    wq.push_back('{REG_P, 16'h0000});
    wq.push_back('{REG_X, 16'h0042});
    wq.push_back('{REG_P, 16'h0000});
    done1 = 0; done2 = 0; first_ready = 0; err_seen = 1'b0;
    bus.req_op_i    = OP_TAX;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_op_i = OP_ILL6;
      if (c == 3) bus.req_op_i = OP_TAX;
      if (c == 7) bus.req_valid_i = 1'b0;
      chk_write("b2b");
      if (bus.err_o) err_seen = 1'b1;
      if (bus.done_o) begin
        if (done1 == 0) done1 = c;
        else if (done2 == 0) done2 = c;
      end
      if (bus.req_ready_o && first_ready == 0) first_ready = c;
    end
    chk("b2b_done1",       32'(done1),       32'd5);
    chk("b2b_ready_again", 32'(first_ready), 32'd6);
    chk("b2b_done2",       32'(done2),       32'd11);
    chk("b2b_no_err",      32'(err_seen),    32'd0);
    chk("b2b_pending",     32'(wq.size()),   32'd0);
    wq.delete();

    // Reset during the P write of a TSX
    load_regs(16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0000);
    wq.push_back('{REG_X, 16'h0010});
    bus.req_op_i    = OP_TSX;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid_i = 1'b0;
      chk_write("tsx_rst");
    end
    @(negedge clk);
    chk("tsx_rst_wrp_we",   32'(bus.rf_we_o),   32'd1);
    chk("tsx_rst_wrp_addr", 32'(bus.rf_addr_o), 32'(REG_P));
    #2 rstn = 1'b0;
    #1;
    chk("tsx_rst_we_drop", 32'(bus.rf_we_o),     32'd0);
    chk("tsx_rst_busy",    32'(bus.busy_o),      32'd0);
    chk("tsx_rst_ready",   32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("tsx_rst_no_done", 32'(bus.done_o), 32'd0);
      chk_write("tsx_rst_after");
    end
    chk("tsx_rst_x_reg",   32'(regs[REG_X]), 32'h0010);
    chk("tsx_rst_p_reg",   32'(regs[REG_P]), 32'h0000);
    chk("tsx_rst_pending", 32'(wq.size()),   32'd0);
    wq.delete();

    tv = '{OP_TAX, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
           1'b1, REG_X, 16'h0001, 1'b1, 16'h0000, 5, 1'b0};
    run_vec("post_rst_tax", tv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
